// File: rtl/alu_pkg.sv
// Shared ALU definitions: result-buffer states and FLAGS bit positions.
// The entry struct is declared where Nbits is known (see adder_result_stage).
package alu_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/adder_flag_gen.sv
// Combinational N/Z/C/V flag derivation from a raw adder result.
module adder_flag_gen
    import alu_pkg::*;
#(
    parameter int Nbits = 4
) (
    input  logic [Nbits-1:0] sum,
    input  logic             c_out,
    input  logic             overflow,
    output logic [3:0]       flags
);

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = sum[Nbits-1];
        flags[FLAG_Z] = (sum == '0);
        flags[FLAG_C] = c_out;
        flags[FLAG_V] = overflow;
    end

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage behind the ripple-carry adder: two-entry skid buffer
// with registered IN_READY, flag capture, sticky overflow and saturating count.
module adder_result_stage
    import alu_pkg::*;
#(
    parameter int Nbits = 4,
    parameter int CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [Nbits-1:0] SUM,
    input  logic             C_OUT,
    input  logic             OVERFLOW,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [Nbits-1:0] RESULT,
    output logic [3:0]       FLAGS,
    input  logic             CLR_STICKY,
    output logic             STICKY_V,
    output logic [CNTW-1:0]  OVF_COUNT
);

    typedef struct packed {
        logic [Nbits-1:0] sum;
        logic [3:0]       flags;
    } entry_t;

    buf_state_e      state_q, state_d;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    logic            sticky_q, sticky_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [3:0] in_flags;
    entry_t     in_entry;
    logic       accept;
    logic       drain;
    logic       accept_v;

    adder_flag_gen #(
        .Nbits(Nbits)
    ) u_flag_gen (
        .sum      (SUM),
        .c_out    (C_OUT),
        .overflow (OVERFLOW),
        .flags    (in_flags)
    );

    assign in_entry  = '{sum: SUM, flags: in_flags};
    assign IN_READY  = (state_q != ST_TWO);
    assign OUT_VALID = (state_q != ST_EMPTY);
    assign RESULT    = main_q.sum;
    assign FLAGS     = main_q.flags;
    assign STICKY_V  = sticky_q;
    assign OVF_COUNT = cnt_q;

    assign accept   = IN_VALID & IN_READY;
    assign drain    = OUT_VALID & OUT_READY;
    assign accept_v = accept & in_flags[FLAG_V];

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_entry;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = in_entry;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = in_entry;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // IN_READY is low here, so only the drain side can move.
                if (drain) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (CLR_STICKY) begin
            // A V=1 entry landing on the clear cycle is counted, not lost.
            sticky_d = accept_v;
            cnt_d    = accept_v ? {{(CNTW-1){1'b0}}, 1'b1} : '0;
        end else if (accept_v) begin
            sticky_d = 1'b1;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage with a queue-based reference model.
module tb_adder_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic       c_out;
    logic       overflow;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic [3:0] flags;
    logic       clr_sticky;
    logic       sticky_v;
    logic [7:0] ovf_count;

    int total = 0;
    int bad   = 0;

    adder_result_stage #(
        .Nbits(4),
        .CNTW (8)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .SUM        (sum),
        .C_OUT      (c_out),
        .OVERFLOW   (overflow),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .RESULT     (result),
        .FLAGS      (flags),
        .CLR_STICKY (clr_sticky),
        .STICKY_V   (sticky_v),
        .OVF_COUNT  (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {sum, flags} of at most two entries.
    logic [7:0] mq[$];
    int         m_cnt;
    bit         m_sticky;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt    = 0;
            m_sticky = 0;
        end else begin
            bit acc, drn, accv;
            acc  = in_valid && (mq.size() < 2);
            drn  = (mq.size() > 0) && out_ready;
            accv = acc && overflow;
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({sum, sum[3], (sum == 4'd0), c_out, overflow});
            if (clr_sticky) begin
                m_sticky = accv;
                m_cnt    = accv ? 1 : 0;
            end else if (accv) begin
                m_sticky = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", int'(out_valid), int'(mq.size() != 0));
            check("in_ready", int'(in_ready), int'(mq.size() < 2));
            if (mq.size() != 0) begin
                check("result", int'(result), int'(mq[0][7:4]));
                check("flags", int'(flags), int'(mq[0][3:0]));
            end
            check("sticky_v", int'(sticky_v), int'(m_sticky));
            check("ovf_count", int'(ovf_count), m_cnt);
        end
    end

    task automatic drive(input logic v, input logic [3:0] s, input logic c, input logic o);
        in_valid = v;
        sum      = s;
        c_out    = c;
        overflow = o;
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero result
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        check("zero_valid", int'(out_valid), 1);
        check("zero_result", int'(result), 0);
        check("zero_flags", int'(flags), 4'b0110);
        @(negedge clk);
        check("zero_drained", int'(out_valid), 0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 4'b0111, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'b1000, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_hold", int'(result), 4'b0111);
        @(negedge clk);
        check("bp_hold2", int'(result), 4'b0111);
        out_ready = 1'b1;
        check("bp_first_res", int'(result), 4'b0111);
        check("bp_first_flg", int'(flags), 4'b0000);
        @(negedge clk);
        check("bp_second_res", int'(result), 4'b1000);
        check("bp_second_flg", int'(flags), 4'b1001);
        check("bp_in_ready_back", int'(in_ready), 1);
        @(negedge clk);
        check("bp_drained", int'(out_valid), 0);

        // Full throughput
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), i[0], i[1]);
            @(negedge clk);
            check("tp_in_ready", int'(in_ready), 1);
            check("tp_valid", int'(out_valid), 1);
            check("tp_result", int'(result), i);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Sticky and clear collision
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 1), 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        check("cnt_three", int'(ovf_count), 3);
        check("sticky_set", int'(sticky_v), 1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("cnt_clr", int'(ovf_count), 0);
        check("sticky_clr", int'(sticky_v), 0);
        clr_sticky = 1'b1;
        drive(1'b1, 4'b0101, 1'b0, 1'b1);
        @(negedge clk);
        clr_sticky = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        check("cnt_collide", int'(ovf_count), 1);
        check("sticky_collide", int'(sticky_v), 1);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'(i), 1'b1, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        check("cnt_sat", int'(ovf_count), 255);
        @(negedge clk);
        check("cnt_sat_hold", int'(ovf_count), 255);
        check("sticky_sat", int'(sticky_v), 1);

        // Reset while holding two entries
        out_ready = 1'b0;
        drive(1'b1, 4'b1010, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        check("two_in_ready", int'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_result", int'(result), 0);
        check("arst_flags", int'(flags), 0);
        check("arst_sticky", int'(sticky_v), 0);
        check("arst_count", int'(ovf_count), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_empty", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_result_stage.md
# adder_result_stage

- Registered output stage placed directly downstream of the ripple-carry adder.
- Captures the adder's SUM, C_OUT and OVERFLOW under a valid/ready handshake and derives the N/Z/C/V flags from them.
- Buffers up to two results in a skid buffer so that IN_READY is a registered signal.
- Keeps a sticky overflow flag and a saturating overflow event counter for the ALU status logic.

## Interface
- Nbits, 4, data width; must match the upstream adder; minimum 2.
- CNTW, 8, width of the overflow event counter.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset; one clock domain.
- IN_VALID  input  1  upstream presents a valid adder result.
- IN_READY  output  1  stage can accept; driven from state only, no combinational path from OUT_READY.
- SUM  input  Nbits  adder sum.
- C_OUT  input  1  adder carry out.
- OVERFLOW  input  1  adder signed overflow.
- OUT_VALID  output  1  RESULT/FLAGS hold a valid entry.
- OUT_READY  input  1  downstream consumes the entry.
- RESULT  output  Nbits  registered sum.
- FLAGS  output  4  {N,Z,C,V} of RESULT.
- CLR_STICKY  input  1  synchronous clear of STICKY_V and OVF_COUNT.
- STICKY_V  output  1  set once any accepted entry had V=1.
- OVF_COUNT  output  CNTW  number of accepted entries with V=1; saturates at all-ones.

## Operation
- **Transfers:**
  - Accept = IN_VALID & IN_READY.
  - Drain = OUT_VALID & OUT_READY.
- **Flags, computed at accept and stored with the entry:**
  - N = SUM[Nbits-1]
  - Z = (SUM == 0)
  - C = C_OUT
  - V = OVERFLOW
- **Storage:** two entries, MAIN (drives outputs) and SKID, each holding {SUM, FLAGS}.
- **States:** EMPTY, ONE (MAIN full), TWO (MAIN and SKID full).
  - EMPTY: accept -> ONE, MAIN loads the input.
  - ONE:
    - accept & drain -> ONE, MAIN loads the input.
    - accept only -> TWO, SKID loads the input.
    - drain only -> EMPTY.
  - TWO: drain -> ONE, MAIN loads SKID. IN_READY=0, so no accept is possible.
- **Handshake outputs:** IN_READY = (state != TWO). OUT_VALID = (state != EMPTY).
- **Ordering and stability:**
  - Strict FIFO order.
  - RESULT/FLAGS stay stable while OUT_VALID & !OUT_READY.
- **Sticky and counter, on an accepted entry with V=1:**
  - STICKY_V <= 1.
  - OVF_COUNT increments, holding at 2^CNTW-1.
- **CLR_STICKY:**
  - Alone: STICKY_V <= 0, OVF_COUNT <= 0.
  - In the same cycle as an accepted V=1: STICKY_V <= 1, OVF_COUNT <= 1.
- **Arithmetic:** no arithmetic on data; SUM passes through unmodified. OVF_COUNT is unsigned, CNTW bits.

## Timing
- **Reset (RST_N low), asynchronous:**
  - State EMPTY.
  - OUT_VALID=0, IN_READY=1.
  - RESULT=0, FLAGS=0, STICKY_V=0, OVF_COUNT=0.
  - SKID is cleared.
  - Values are held until the first rising edge after release.
- **Reset mid-operation:** any buffered entries are discarded; no drain follows.
- **Latency:** accept at edge k -> OUT_VALID=1 with that entry after edge k.
- **Throughput:** one entry per cycle when OUT_READY is held high.
- **Stall response:**
  - IN_READY falls one cycle after the stall fills SKID.
  - IN_READY rises the cycle after SKID empties.

## Structure
- **Shared package alu_pkg:**
  - State enum {EMPTY, ONE, TWO}.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Entry struct {sum, flags}, parameterized through Nbits at the point of use.
- **Sub-module adder_flag_gen** (combinational, instantiated once on the input path): SUM/C_OUT/OVERFLOW -> FLAGS.
- **In the top:** state machine, two entry registers, sticky logic and counter.

## Test plan
All scenarios use Nbits=4, CNTW=8.
- **Reset:** drive RST_N low while in TWO -> immediately OUT_VALID=0, IN_READY=1, RESULT=0, FLAGS=0, STICKY_V=0, OVF_COUNT=0.
- **Zero result:** accept SUM=0000, C_OUT=1, OVERFLOW=0 with OUT_READY=1 -> next cycle OUT_VALID=1, RESULT=0000, FLAGS=0110; the cycle after that OUT_VALID=0.
- **Backpressure:**
  - With OUT_READY=0, accept SUM=0111/V=0, then SUM=1000/C=0/V=1 -> IN_READY=0, RESULT holds 0111.
  - Raise OUT_READY -> outputs 0111/FLAGS=0000, then 1000/FLAGS=1001, then OUT_VALID=0.
- **Full throughput:** IN_VALID=1 and OUT_READY=1 continuously for 16 values -> state stays ONE, IN_READY stays 1, outputs follow inputs in order with 1-cycle latency and no bubbles.
- **Sticky clear collision:**
  - After 3 accepted V=1 entries -> OVF_COUNT=3, STICKY_V=1.
  - Assert CLR_STICKY with no accept -> 0/0.
  - Assert CLR_STICKY together with an accepted V=1 -> OVF_COUNT=1, STICKY_V=1.
- **Saturation:** 300 accepted V=1 entries -> OVF_COUNT=255 and holds; STICKY_V=1.
